// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM
// and registers the returned word into IF/ID, with stall, branch redirect/flush and halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_rd,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus8,
    output logic        if_valid,
    output logic        halted,
    output logic        align_err,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, HALTED} state_t;

    // One past the last populated byte address, widened so large depths cannot overflow.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] eff_target;
    logic        in_range;
    logic        target_in_range;

    assign eff_target      = {branch_target[31:2], 2'b00};
    assign in_range        = {1'b0, pc} < PC_LIMIT;
    assign target_in_range = {1'b0, eff_target} < PC_LIMIT;

    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign if_pc_plus8 = if_pc + 32'd8;
    assign halted      = (state == HALTED);

    // Priority is reset, then redirect (which wins even over a stall), then stall, then advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= RUN;
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            if_valid    <= 1'b0;
            fetch_count <= 32'd0;
            align_err   <= 1'b0;
        end else begin
            align_err <= branch_taken && (branch_target[1:0] != 2'b00);
            if (branch_taken) begin
                pc       <= eff_target;
                if_instr <= 32'd0;
                if_pc    <= 32'd0;
                if_valid <= 1'b0;
                state    <= target_in_range ? RUN : HALTED;
            end else if (!stall) begin
                if (state == RUN && in_range) begin
                    if_instr    <= imem_rd;
                    if_pc       <= pc;
                    if_valid    <= 1'b1;
                    fetch_count <= fetch_count + 32'd1;
                    pc          <= pc + 32'd4;
                end else begin
                    // Ran off the ROM (or already halted): park the PC and feed bubbles.
                    if_instr <= 32'd0;
                    if_pc    <= 32'd0;
                    if_valid <= 1'b0;
                    state    <= HALTED;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven vectors through a scoreboard queue,
// plus a hand-written run-off-the-end sequence on a small-ROM instance.
module tb_fetch_stage;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_halted;
        logic        e_align;
        logic [31:0] e_count;
        logic        chk_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;

    logic [31:0] imem_rd, imem_addr, pc_plus4, if_instr, if_pc, if_pc_plus8, fetch_count;
    logic        if_valid, halted, align_err;

    logic [31:0] s_imem_rd, s_imem_addr, s_pc_plus4, s_if_instr, s_if_pc, s_if_pc_plus8, s_fetch_count;
    logic        s_if_valid, s_halted, s_align_err;

    int checkCount = 0;
    int passCount  = 0;
    vec_t tbl[$];
    vec_t expQ[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(100)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .pc_plus4(pc_plus4), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus8(if_pc_plus8),
        .if_valid(if_valid), .halted(halted), .align_err(align_err), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_rd(s_imem_rd), .imem_addr(s_imem_addr),
        .pc_plus4(s_pc_plus4), .if_instr(s_if_instr), .if_pc(s_if_pc), .if_pc_plus8(s_if_pc_plus8),
        .if_valid(s_if_valid), .halted(s_halted), .align_err(s_align_err), .fetch_count(s_fetch_count)
    );

    // ROM contents: first three words from the program listing, then a tagged filler word.
    function automatic logic [31:0] romWord(input logic [31:0] addr);
        logic [29:0] idx;
        idx = addr[31:2];
        case (idx)
            30'd0:   return 32'hE3A0_0001;
            30'd1:   return 32'hE3A0_1002;
            30'd2:   return 32'hE080_2001;
            default: return 32'hEA00_0000 | {8'h00, idx[23:0]};
        endcase
    endfunction

    always_comb imem_rd   = romWord(imem_addr);
    always_comb s_imem_rd = romWord(s_imem_addr);

    function automatic vec_t mkVec(input logic rst, input logic stl, input logic br,
                                   input logic [31:0] tgt, input logic [31:0] addr,
                                   input logic [31:0] instr, input logic [31:0] pc,
                                   input logic valid, input logic hlt, input logic aln,
                                   input logic [31:0] cnt, input logic chk);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt;
        v.e_addr = addr; v.e_instr = instr; v.e_pc = pc; v.e_valid = valid;
        v.e_halted = hlt; v.e_align = aln; v.e_count = cnt; v.chk_data = chk;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic driveCycle(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        expQ.push_back(v);
        driveCycle(v.rst, v.stl, v.br, v.tgt);
    endtask

    task automatic compareRow(input int idx);
        vec_t v;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL row%0d_queue: got empty scoreboard, expected an entry", idx);
            return;
        end
        v = expQ.pop_front();
        checkOutput($sformatf("row%0d_imem_addr", idx), imem_addr, v.e_addr);
        checkOutput($sformatf("row%0d_pc_plus4", idx), pc_plus4, v.e_addr + 32'd4);
        checkOutput($sformatf("row%0d_if_valid", idx), {31'd0, if_valid}, {31'd0, v.e_valid});
        checkOutput($sformatf("row%0d_halted", idx), {31'd0, halted}, {31'd0, v.e_halted});
        checkOutput($sformatf("row%0d_align_err", idx), {31'd0, align_err}, {31'd0, v.e_align});
        checkOutput($sformatf("row%0d_fetch_count", idx), fetch_count, v.e_count);
        if (v.chk_data) begin
            checkOutput($sformatf("row%0d_if_instr", idx), if_instr, v.e_instr);
            checkOutput($sformatf("row%0d_if_pc", idx), if_pc, v.e_pc);
            checkOutput($sformatf("row%0d_if_pc_plus8", idx), if_pc_plus8, v.e_pc + 32'd8);
        end
    endtask

    initial begin
        //                 rst stl br  tgt            addr           instr          pc             v  h  a  cnt chk
        tbl.push_back(mkVec(1, 0, 0, 32'h0,   32'h0,   32'h0,        32'h0,   0, 0, 0, 0, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h4,   32'hE3A00001, 32'h0,   1, 0, 0, 1, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h8,   32'hE3A01002, 32'h4,   1, 0, 0, 2, 1));
        tbl.push_back(mkVec(0, 1, 0, 32'h0,   32'h8,   32'hE3A01002, 32'h4,   1, 0, 0, 2, 1));
        tbl.push_back(mkVec(0, 1, 0, 32'h0,   32'h8,   32'hE3A01002, 32'h4,   1, 0, 0, 2, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'hC,   32'hE0802001, 32'h8,   1, 0, 0, 3, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h10,  32'hEA000003, 32'hC,   1, 0, 0, 4, 1));
        tbl.push_back(mkVec(0, 1, 1, 32'h20,  32'h20,  32'h0,        32'h0,   0, 0, 0, 4, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h24,  32'hEA000008, 32'h20,  1, 0, 0, 5, 1));
        tbl.push_back(mkVec(0, 0, 1, 32'h22,  32'h20,  32'h0,        32'h0,   0, 0, 1, 5, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h24,  32'hEA000008, 32'h20,  1, 0, 0, 6, 1));
        tbl.push_back(mkVec(0, 0, 1, 32'h190, 32'h190, 32'h0,        32'h0,   0, 1, 0, 6, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h190, 32'h0,        32'h0,   0, 1, 0, 6, 0));
        tbl.push_back(mkVec(0, 0, 1, 32'h18F, 32'h18C, 32'h0,        32'h0,   0, 0, 1, 6, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h190, 32'hEA000063, 32'h18C, 1, 0, 0, 7, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h190, 32'h0,        32'h0,   0, 1, 0, 7, 0));
        tbl.push_back(mkVec(0, 1, 0, 32'h0,   32'h190, 32'h0,        32'h0,   0, 1, 0, 7, 0));
        tbl.push_back(mkVec(1, 0, 0, 32'h0,   32'h0,   32'h0,        32'h0,   0, 0, 0, 0, 1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0,   32'h4,   32'hE3A00001, 32'h0,   1, 0, 0, 1, 1));
        tbl.push_back(mkVec(1, 1, 1, 32'h40,  32'h0,   32'h0,        32'h0,   0, 0, 0, 0, 1));

        $display("[TB] applying %0d table vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            compareRow(i);
        end

        // Small ROM: free run must park the PC just past the last word and stop fetching.
        driveCycle(1, 0, 0, 32'h0);
        checkOutput("small_reset_addr", s_imem_addr, 32'h0);
        for (int c = 0; c < 20 && !s_halted; c++) driveCycle(0, 0, 0, 32'h0);
        checkOutput("small_halt_reached", {31'd0, s_halted}, 32'd1);
        checkOutput("small_halt_addr", s_imem_addr, 32'h10);
        checkOutput("small_halt_count", s_fetch_count, 32'd4);
        for (int c = 0; c < 3; c++) begin
            driveCycle(0, 0, 0, 32'h0);
            checkOutput($sformatf("small_park%0d_addr", c), s_imem_addr, 32'h10);
            checkOutput($sformatf("small_park%0d_valid", c), {31'd0, s_if_valid}, 32'd0);
            checkOutput($sformatf("small_park%0d_halted", c), {31'd0, s_halted}, 32'd1);
        end
        driveCycle(0, 0, 1, 32'h0);
        checkOutput("small_resume_addr", s_imem_addr, 32'h0);
        checkOutput("small_resume_halted", {31'd0, s_halted}, 32'd0);
        driveCycle(0, 0, 0, 32'h0);
        checkOutput("small_resume_valid", {31'd0, s_if_valid}, 32'd1);
        checkOutput("small_resume_instr", s_if_instr, 32'hE3A00001);
        checkOutput("small_resume_count", s_fetch_count, 32'd5);

        // Reset while halted with a nonzero count must clear everything at once.
        for (int c = 0; c < 6; c++) driveCycle(0, 0, 0, 32'h0);
        checkOutput("small_rehalt", {31'd0, s_halted}, 32'd1);
        driveCycle(1, 0, 0, 32'h0);
        checkOutput("small_rst_addr", s_imem_addr, 32'h0);
        checkOutput("small_rst_halted", {31'd0, s_halted}, 32'd0);
        checkOutput("small_rst_count", s_fetch_count, 32'd0);
        checkOutput("small_rst_valid", {31'd0, s_if_valid}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: holds the program counter, drives the address of the instruction ROM, and captures the returned 32-bit word into the IF/ID pipeline register. The ROM is a combinational 32-bit read port indexed by word (address/4), with IMEM_DEPTH words. The fetch stage handles sequential PC+4 advance, stalls, branch redirection with flush, and a halt state when the PC leaves the populated ROM range.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_DEPTH, 100: number of 32-bit words in the instruction ROM. Valid fetch range is byte addresses 0 to 4*IMEM_DEPTH-4.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents (hazard unit).
- branch_taken  in  1  redirect request from execute stage.
- branch_target  in  32  redirect byte address.
- imem_rd  in  32  instruction word returned by ROM for imem_addr.
- imem_addr  out  32  current PC, drives ROM address.
- pc_plus4  out  32  imem_addr + 4, combinational.
- if_instr  out  32  registered instruction.
- if_pc  out  32  registered PC of if_instr.
- if_pc_plus8  out  32  if_pc + 8, combinational (architectural PC read value).
- if_valid  out  1  if_instr holds a real instruction (0 = bubble).
- halted  out  1  FSM in HALTED.
- align_err  out  1  one-cycle pulse: branch_target[1:0] was nonzero.
- fetch_count  out  32  number of instructions loaded into IF/ID with if_valid=1.

## Operation
- FSM states: RUN, HALTED. Reset state RUN.
- in_range = (PC < 4*IMEM_DEPTH), unsigned compare.
- Effective target = {branch_target[31:2], 2'b00}; align_err asserted the cycle after any accepted branch with nonzero low bits.
- Per-cycle priority (highest first): reset > branch_taken > stall > normal advance.
- reset: PC=RESET_PC, state=RUN, if_instr=0, if_pc=0, if_valid=0, fetch_count=0, align_err=0.
- branch_taken (any state, regardless of stall): PC=effective target; IF/ID flushed (if_valid=0, if_instr=0, if_pc=0); state=RUN if target in range, otherwise HALTED.
- stall (no branch): PC, IF/ID, state, and fetch_count are unchanged.
- RUN, normal, in_range: IF/ID is loaded with imem_rd and PC; if_valid=1; fetch_count+1; PC=PC+4 (mod 2^32).
- RUN, normal, not in_range: state=HALTED; PC holds; IF/ID loaded with a bubble.
- HALTED, no branch: PC holds; IF/ID gets a bubble every cycle. Only branch_taken or reset leaves this state.
- fetch_count wraps from 2^32-1 to 0.
- halted = (state==HALTED), registered.

## Timing
- imem_addr is registered (the PC). The ROM is combinational, so imem_rd is sampled in the same cycle. The instruction appears on if_instr one cycle after its PC is on imem_addr.
- Redirect latency: branch_taken in cycle N puts the target on imem_addr in N+1. The target instruction is valid on if_instr in N+2. Exactly one bubble is inserted.
- Stall has zero-cycle response. Outputs are frozen on the edge that ends the stalled cycle.
- PC wrap: PC=0xFFFF_FFFC advancing gives 0 (only reachable with a redirect and a large IMEM_DEPTH; it is not an error).
- Reset asserted mid-stall, mid-branch, or in HALTED overrides everything at that edge.

## Test plan
- Reset then 3 free-running cycles, ROM words 0xE3A00001, 0xE3A01002, 0xE0802001: imem_addr goes 0→4→8→12. if_instr/if_pc give (0xE3A00001,0), (0xE3A01002,4). fetch_count=3.
- stall high for 2 cycles at PC=8: imem_addr stays 8. if_instr stays the word at 4. fetch_count does not change. Release resumes with the word at 8.
- branch_taken with target 0x20 at PC=0x10, stall also high: next cycle imem_addr=0x20 and if_valid=0. The following cycle if_pc=0x20 and if_valid=1.
- branch_target=0x22: PC becomes 0x20 and align_err pulses for 1 cycle.
- IMEM_DEPTH=4, free run from 0: after PC=12, PC sticks at 16, halted=1, and if_valid stays 0. A branch to 0 returns to RUN with halted=0.
- reset asserted while HALTED with fetch_count=5: next cycle PC=RESET_PC, halted=0, fetch_count=0, if_valid=0.
